alu_arbiter: RTL
================

// Module: alu_arbiter
// PURPOSE
//   Shares the single-cycle 32-bit ALU between two requesters (e.g. main
//   datapath and branch/address unit). Round-robin grant, valid/ready request
//   channels, one registered response channel tagged with requester id.
//   Drives ALU operands/op combinationally and captures ALU result in an
//   output slot. Sits between requesters and the ALU instance.
// PARAMETERS
//   WIDTH      32   operand/result width (matches ALU)
//   FW         4    ALU function-code width
// PORTS
//   clk          in   1      clock, rising edge
//   reset        in   1      asynchronous, active-high reset
//   req0_valid   in   1      requester 0 has an operation
//   req0_ready   out  1      requester 0 operation accepted this cycle
//   req0_a/b     in   WIDTH  operands
//   req0_f       in   FW     ALU function code
//   req0_shamt   in   5      shift amount
//   req1_*       -    -      identical set for requester 1
//   alu_a/b      out  WIDTH  to ALU
//   alu_f        out  FW     to ALU
//   alu_shamt    out  5      to ALU
//   alu_y        in   WIDTH  from ALU (combinational)
//   alu_zero     in   1      from ALU
//   rsp_valid    out  1      response slot holds a result
//   rsp_ready    in   1      consumer takes result this cycle
//   rsp_id       out  1      requester that issued the result
//   rsp_y        out  WIDTH  registered ALU result
//   rsp_zero     out  1      registered ALU zero flag
// BEHAVIOUR
//   - Reset: rsp_valid=0, rsp_id=0, rsp_y=0, rsp_zero=0, last_grant=1
//     (req0 wins first tie), lock cleared. Held result discarded.
//   - slot_free = !rsp_valid | rsp_ready.
//   - Grant (comb): only one valid -> that one; both valid -> requester
//     != last_grant; none -> no grant.
//   - reqN_ready = grantN & slot_free. Never both high. Accept = valid&ready.
//   - ALU drive: granted request's a,b,f,shamt; no grant -> all zero.
//     Drive is independent of slot_free (ALU always sees granted op).
//   - On accept (edge): rsp_y<=alu_y, rsp_zero<=alu_zero, rsp_id<=grant,
//     rsp_valid<=1, last_grant<=grant.
//   - No accept & rsp_ready: rsp_valid<=0. No accept & !rsp_ready: hold all.
//   - Latency 1: accept in cycle N -> rsp_valid in N+1. Throughput 1 op/clk
//     while rsp_ready=1 (drain and refill same edge).
//   - last_grant changes only on accept; stalled grant does not rotate.
//   - Requester holds a,b,f,shamt stable while valid & !ready; may not
//     drop valid before accept.
//   - FSM: EMPTY (rsp_valid=0) / FULL (rsp_valid=1). EMPTY->FULL on accept;
//     FULL->EMPTY on rsp_ready & !accept; FULL->FULL on accept or stall.
//   - rsp_* stable while rsp_valid & !rsp_ready.
// CONFIGURATION
//   ALU_ARB_LOCK_EN defined: adds inputs req0_lock, req1_lock (1 bit).
//     Accept with lock=1 pins grant to that requester (other gets ready=0
//     even if valid) until it has an accept with lock=0; last_grant then
//     updates normally. Reset clears lock.
//   Not defined: ports absent, pure round-robin as above.
// TESTING
//   1 req0 a=5,b=7,f=0010, rsp_ready=1 -> next clk rsp_valid=1,id=0,y=12,zero=0
//   2 both valid every clk, rsp_ready=1 -> ids 0,1,0,1...; one accept/clk
//   3 req0 a=b=9,f=0110, rsp_ready=0 3 clks -> y=0,zero=1 held stable,
//     req0/req1 ready=0 while slot full; ready returns same clk rsp_ready=1
//   4 rsp_valid=1, assert reset mid-hold -> rsp_valid=0 immediately (async);
//     after release, both valid -> req0 granted first
//   5 ALU_ARB_LOCK_EN: req1 lock=1 x3 then lock=0 with req0 valid throughout
//     -> 4 consecutive id=1 results, then id=0
//   6 f=0011,b=1,shamt=31 via req1 -> y=0x80000000,id=1; idle -> alu_f=0

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one single-cycle ALU between two requesters, with a registered response slot.
// Optional build macro ALU_ARB_LOCK_EN adds req0_lock/req1_lock to pin the grant across a locked sequence.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int FW    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FW-1:0]    req0_f,
    input  logic [4:0]       req0_shamt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FW-1:0]    req1_f,
    input  logic [4:0]       req1_shamt,
`ifdef ALU_ARB_LOCK_EN
    input  logic             req0_lock,
    input  logic             req1_lock,
`endif
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FW-1:0]    alu_f,
    output logic [4:0]       alu_shamt,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_y,
    output logic             rsp_zero,
    output logic             dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // Requesters keep valid and operands stable until ready; the response slot holds until rsp_ready.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t state_q, state_d;
    logic   last_grant_q;
    logic   rr_valid, rr_id;
    logic   gnt_valid, gnt_id;
    logic   slot_free, accept;

`ifdef ALU_ARB_LOCK_EN
    logic   lock_act_q, lock_id_q;
`endif

    always_comb begin
        rr_valid = req0_valid | req1_valid;
        rr_id    = 1'b0;
        if (req0_valid && req1_valid) begin
            rr_id = ~last_grant_q;
        end else if (req1_valid) begin
            rr_id = 1'b1;
        end
    end

    always_comb begin
        gnt_valid = rr_valid;
        gnt_id    = rr_id;
`ifdef ALU_ARB_LOCK_EN
        // While pinned, only the lock owner may be granted, even if it is idle.
        if (lock_act_q) begin
            gnt_id    = lock_id_q;
            gnt_valid = lock_id_q ? req1_valid : req0_valid;
        end
`endif
    end

    assign slot_free  = (state_q == EMPTY) | rsp_ready;
    assign accept     = gnt_valid & slot_free;
    assign req0_ready = gnt_valid & ~gnt_id & slot_free;
    assign req1_ready = gnt_valid & gnt_id & slot_free;

    always_comb begin
        alu_a     = '0;
        alu_b     = '0;
        alu_f     = '0;
        alu_shamt = '0;
        if (gnt_valid) begin
            if (gnt_id) begin
                alu_a     = req1_a;
                alu_b     = req1_b;
                alu_f     = req1_f;
                alu_shamt = req1_shamt;
            end else begin
                alu_a     = req0_a;
                alu_b     = req0_b;
                alu_f     = req0_f;
                alu_shamt = req0_shamt;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (!accept && rsp_ready) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    assign rsp_valid = (state_q == FULL);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_y        <= '0;
            rsp_zero     <= 1'b0;
            rsp_id       <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            rsp_y        <= alu_y;
            rsp_zero     <= alu_zero;
            rsp_id       <= gnt_id;
            last_grant_q <= gnt_id;
        end
    end

`ifdef ALU_ARB_LOCK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lock_act_q <= 1'b0;
            lock_id_q  <= 1'b0;
        end else if (accept) begin
            lock_act_q <= gnt_id ? req1_lock : req0_lock;
            lock_id_q  <= gnt_id;
        end
    end
`endif

endmodule
